// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the 8-bit RISC-V memory stage.
// Holds the state encodings, the bubble control word and the data-path widths.
package mem_stage_pkg;

  localparam int DATA_W = 8;
  localparam int ADDR_W = 8;
  localparam int CNT_W  = 8;

  typedef enum logic {
    MEM_IDLE = 1'b0,
    MEM_WAIT = 1'b1
  } mem_state_e;

  typedef struct packed {
    logic mem_to_reg;
    logic reg_write;
  } wb_ctrl_t;

  // A bubble must never write the register file.
  localparam wb_ctrl_t BUBBLE_CTRL = '{mem_to_reg: 1'b0, reg_write: 1'b0};

endpackage

// File: rtl/mem_stage_dmem_handshake_ctrl.sv
// Data-memory handshake controller: IDLE/WAIT FSM, timeout counter, dmem_* registers,
// stall generation and the sticky bus_error flag.
module dmem_handshake_ctrl
  import mem_stage_pkg::*;
#(
  parameter int TIMEOUT = 15
) (
  input  logic              i_clock,
  input  logic              i_reset,
  input  logic              i_mem_read,
  input  logic              i_mem_write,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic              i_dmem_ack,
  input  logic [DATA_W-1:0] i_dmem_rdata,
  output logic              o_dmem_req,
  output logic              o_dmem_we,
  output logic [ADDR_W-1:0] o_dmem_addr,
  output logic [DATA_W-1:0] o_dmem_wdata,
  output logic              o_stall,
  output logic              o_done,
  output logic [DATA_W-1:0] o_load_data,
  output logic              o_bus_error,
  output logic              o_state
);

  // Handshake: dmem_req rises on the edge leaving IDLE and stays high until the
  // cycle in which dmem_ack (a one-cycle pulse, rdata valid alongside) is seen,
  // or the wait counter expires; req then drops on the following edge.
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  mem_state_e        r_state;
  logic [CNT_W-1:0]  r_cnt;
  logic              r_dmem_req;
  logic              r_dmem_we;
  logic [ADDR_W-1:0] r_dmem_addr;
  logic [DATA_W-1:0] r_dmem_wdata;
  logic              r_bus_error;

  logic w_access;
  logic w_expired;
  logic w_done;
  logic w_timeout;

  assign w_access  = i_mem_read | i_mem_write;
  assign w_expired = (r_cnt == TIMEOUT_CNT);
  assign w_done    = (r_state == MEM_WAIT) && (i_dmem_ack || w_expired);
  assign w_timeout = (r_state == MEM_WAIT) && w_expired && !i_dmem_ack;

  // Gated by reset so the pipeline is released immediately while reset is low.
  assign o_stall = i_reset &&
                   (((r_state == MEM_IDLE) && w_access) ||
                    ((r_state == MEM_WAIT) && !w_done));

  assign o_done      = w_done;
  assign o_load_data = (w_done && i_dmem_ack && !r_dmem_we) ? i_dmem_rdata : '0;

  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_state      <= MEM_IDLE;
      r_cnt        <= '0;
      r_dmem_req   <= 1'b0;
      r_dmem_we    <= 1'b0;
      r_dmem_addr  <= '0;
      r_dmem_wdata <= '0;
      r_bus_error  <= 1'b0;
    end else begin
      case (r_state)
        MEM_IDLE: begin
          if (w_access) begin
            r_state      <= MEM_WAIT;
            r_cnt        <= '0;
            r_dmem_req   <= 1'b1;
            r_dmem_we    <= i_mem_write;
            r_dmem_addr  <= i_addr;
            r_dmem_wdata <= i_wdata;
          end
        end
        MEM_WAIT: begin
          if (w_done) begin
            r_state    <= MEM_IDLE;
            r_cnt      <= '0;
            r_dmem_req <= 1'b0;
            if (w_timeout) begin
              r_bus_error <= 1'b1;
            end
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: begin
          r_state    <= MEM_IDLE;
          r_dmem_req <= 1'b0;
        end
      endcase
    end
  end

  assign o_dmem_req   = r_dmem_req;
  assign o_dmem_we    = r_dmem_we;
  assign o_dmem_addr  = r_dmem_addr;
  assign o_dmem_wdata = r_dmem_wdata;
  assign o_bus_error  = r_bus_error;
  assign o_state      = r_state;

endmodule

// File: rtl/mem_stage.sv
// Memory stage of the 8-bit RISC-V pipeline: branch resolution, data-memory
// access through dmem_handshake_ctrl, and the MEM/WB pipeline register.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int PC_SIZE = 10,
  parameter int TIMEOUT = 15
) (
  input  logic               i_clock,
  input  logic               i_reset,
  input  logic [PC_SIZE-1:0] i_pc_jump,
  input  logic               i_zero,
  input  logic [DATA_W-1:0]  i_alu_result,
  input  logic [DATA_W-1:0]  i_write_data,
  input  logic               i_branch,
  input  logic               i_mem_read,
  input  logic               i_mem_write,
  input  logic               i_mem_to_reg,
  input  logic               i_reg_write,
  input  logic [4:0]         i_write_register,
  input  logic               i_dmem_ack,
  input  logic [DATA_W-1:0]  i_dmem_rdata,
  output logic               o_dmem_req,
  output logic               o_dmem_we,
  output logic [ADDR_W-1:0]  o_dmem_addr,
  output logic [DATA_W-1:0]  o_dmem_wdata,
  output logic               o_stall,
  output logic               o_pc_src,
  output logic [PC_SIZE-1:0] o_pc_target,
  output logic [DATA_W-1:0]  o_read_data_out,
  output logic [DATA_W-1:0]  o_alu_result_out,
  output logic               o_mem_to_reg_out,
  output logic               o_reg_write_out,
  output logic [4:0]         o_write_register_out,
  output logic [DATA_W-1:0]  o_wb_write_data,
  output logic               o_bus_error,
  output logic               o_dbg_state
);

  logic              w_stall;
  logic              w_done;
  logic [DATA_W-1:0] w_load_data;

  logic [DATA_W-1:0] r_read_data;
  logic [DATA_W-1:0] r_alu_result;
  wb_ctrl_t          r_ctrl;
  logic [4:0]        r_write_register;

  dmem_handshake_ctrl #(
    .TIMEOUT(TIMEOUT)
  ) u_ctrl (
    .i_clock      (i_clock),
    .i_reset      (i_reset),
    .i_mem_read   (i_mem_read),
    .i_mem_write  (i_mem_write),
    .i_addr       (i_alu_result),
    .i_wdata      (i_write_data),
    .i_dmem_ack   (i_dmem_ack),
    .i_dmem_rdata (i_dmem_rdata),
    .o_dmem_req   (o_dmem_req),
    .o_dmem_we    (o_dmem_we),
    .o_dmem_addr  (o_dmem_addr),
    .o_dmem_wdata (o_dmem_wdata),
    .o_stall      (w_stall),
    .o_done       (w_done),
    .o_load_data  (w_load_data),
    .o_bus_error  (o_bus_error),
    .o_state      (o_dbg_state)
  );

  // A completing access may coincide with the timeout cycle, where stall is low
  // as well, so completion is tested before the plain pass-through case.
  always_ff @(posedge i_clock or negedge i_reset) begin
    if (!i_reset) begin
      r_read_data      <= '0;
      r_alu_result     <= '0;
      r_ctrl           <= BUBBLE_CTRL;
      r_write_register <= '0;
    end else if (w_done) begin
      r_read_data      <= w_load_data;
      r_alu_result     <= i_alu_result;
      r_ctrl           <= '{mem_to_reg: i_mem_to_reg, reg_write: i_reg_write};
      r_write_register <= i_write_register;
    end else if (!w_stall) begin
      r_read_data      <= '0;
      r_alu_result     <= i_alu_result;
      r_ctrl           <= '{mem_to_reg: i_mem_to_reg, reg_write: i_reg_write};
      r_write_register <= i_write_register;
    end else begin
      r_read_data      <= '0;
      r_alu_result     <= '0;
      r_ctrl           <= BUBBLE_CTRL;
      r_write_register <= '0;
    end
  end

  assign o_stall              = w_stall;
  assign o_pc_src             = i_branch & i_zero & ~w_stall;
  assign o_pc_target          = i_pc_jump;
  assign o_read_data_out      = r_read_data;
  assign o_alu_result_out     = r_alu_result;
  assign o_mem_to_reg_out     = r_ctrl.mem_to_reg;
  assign o_reg_write_out      = r_ctrl.reg_write;
  assign o_write_register_out = r_write_register;
  assign o_wb_write_data      = r_ctrl.mem_to_reg ? r_read_data : r_alu_result;

endmodule
